// File: rtl/ppu_fix_responder.sv
// Fixed-point (Q16.16) arithmetic responder: saturating ADD/SUB/MUL in one
// execute cycle, DIV via a multi-cycle restoring divider.
`timescale 1ns/1ps

module ppu_fix_responder #(
    parameter int PPU_OP_WIDTH = 3,
    parameter int DIV_ITER     = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ppu_valid_in,
    input  logic [31:0]             ppu_in1,
    input  logic [31:0]             ppu_in2,
    input  logic [PPU_OP_WIDTH-1:0] ppu_op,
    output logic [31:0]             ppu_out,
    output logic                    ppu_valid_o,
    output logic                    ppu_busy_o
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    localparam logic [PPU_OP_WIDTH-1:0] OP_ADD = PPU_OP_WIDTH'(0);
    localparam logic [PPU_OP_WIDTH-1:0] OP_SUB = PPU_OP_WIDTH'(1);
    localparam logic [PPU_OP_WIDTH-1:0] OP_MUL = PPU_OP_WIDTH'(2);
    localparam logic [PPU_OP_WIDTH-1:0] OP_DIV = PPU_OP_WIDTH'(3);

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_valid;
    logic                    w_busy;

    logic [31:0]             r_a;
    logic [31:0]             r_b;
    logic [PPU_OP_WIDTH-1:0] r_op;
    logic [CNT_W-1:0]        r_cnt;
    logic [31:0]             r_rem;
    logic [47:0]             r_quot;
    logic [31:0]             r_out;

    logic                    w_capture;
    logic                    w_cnt_last;
    logic [31:0]             w_a_mag_in;
    logic [31:0]             w_b_mag;
    logic [32:0]             w_rem_sh;
    logic [32:0]             w_rem_sub;
    logic                    w_q_bit;

    logic [32:0]             w_sum_add;
    logic [32:0]             w_sum_sub;
    logic signed [63:0]      w_prod;
    logic signed [63:0]      w_prod_sh;
    logic                    w_div_neg;
    logic                    w_div_pos_ovf;
    logic                    w_div_neg_ovf;
    logic [31:0]             w_quot_neg;
    logic [31:0]             w_result;

    assign w_capture  = (r_state == S_IDLE) && ppu_valid_in;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (ppu_valid_in) begin
                    if ((ppu_op == OP_DIV) && (ppu_in2 != 32'd0)) begin
                        w_state_next = S_DIV_RUN;
                    end else begin
                        w_state_next = S_EXEC;
                    end
                end
            end
            S_DIV_RUN: begin
                if (w_cnt_last) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_valid      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign ppu_valid_o = w_valid;
    assign ppu_busy_o  = w_busy;
    assign ppu_out     = r_out;

    // ------------------------------------------------------------------
    // Restoring divider step on magnitudes; quotient bits shift into r_quot
    // as dividend bits shift out of its top.
    // ------------------------------------------------------------------
    assign w_a_mag_in = ppu_in1[31] ? (~ppu_in1 + 32'd1) : ppu_in1;
    assign w_b_mag    = r_b[31] ? (~r_b + 32'd1) : r_b;
    assign w_rem_sh   = {r_rem, r_quot[47]};
    assign w_rem_sub  = w_rem_sh - {1'b0, w_b_mag};
    assign w_q_bit    = ~w_rem_sub[32];

    // ------------------------------------------------------------------
    // Result formation for the execute cycle
    // ------------------------------------------------------------------
    assign w_sum_add = {r_a[31], r_a} + {r_b[31], r_b};
    assign w_sum_sub = {r_a[31], r_a} - {r_b[31], r_b};
    assign w_prod    = $signed(r_a) * $signed(r_b);
    assign w_prod_sh = w_prod >>> 16;

    assign w_div_neg     = r_a[31] ^ r_b[31];
    assign w_div_pos_ovf = (r_quot > 48'h0000_7FFF_FFFF);
    assign w_div_neg_ovf = (r_quot > 48'h0000_8000_0000);
    assign w_quot_neg    = ~r_quot[31:0] + 32'd1;

    always_comb begin
        w_result = 32'd0;
        case (r_op)
            OP_ADD: begin
                if (w_sum_add[32] ^ w_sum_add[31]) begin
                    w_result = w_sum_add[32] ? SAT_NEG : SAT_POS;
                end else begin
                    w_result = w_sum_add[31:0];
                end
            end
            OP_SUB: begin
                if (w_sum_sub[32] ^ w_sum_sub[31]) begin
                    w_result = w_sum_sub[32] ? SAT_NEG : SAT_POS;
                end else begin
                    w_result = w_sum_sub[31:0];
                end
            end
            OP_MUL: begin
                if (w_prod_sh > 64'sh0000_0000_7FFF_FFFF) begin
                    w_result = SAT_POS;
                end else if (w_prod_sh < -64'sh0000_0000_8000_0000) begin
                    w_result = SAT_NEG;
                end else begin
                    w_result = w_prod_sh[31:0];
                end
            end
            OP_DIV: begin
                // Divide-by-zero never enters the divider; saturate toward A's sign.
                if (r_b == 32'd0) begin
                    w_result = r_a[31] ? SAT_NEG : SAT_POS;
                end else if (w_div_neg) begin
                    w_result = w_div_neg_ovf ? SAT_NEG : w_quot_neg;
                end else begin
                    w_result = w_div_pos_ovf ? SAT_POS : r_quot[31:0];
                end
            end
            default: begin
                w_result = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_rem  <= 32'd0;
            r_quot <= 48'd0;
            r_out  <= 32'd0;
        end else begin
            if (w_capture) begin
                r_a    <= ppu_in1;
                r_b    <= ppu_in2;
                r_op   <= ppu_op;
                r_cnt  <= '0;
                r_rem  <= 32'd0;
                r_quot <= {w_a_mag_in, 16'd0};
            end
            if (r_state == S_DIV_RUN) begin
                r_rem  <= w_q_bit ? w_rem_sub[31:0] : w_rem_sh[31:0];
                r_quot <= {r_quot[46:0], w_q_bit};
                if (!w_cnt_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == S_EXEC) begin
                r_out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_ppu_fix_responder.sv
// Bench for ppu_fix_responder: a latency/arithmetic model checked every cycle,
// plus directed vectors with hand-computed results and completion cycles.
`timescale 1ns/1ps

module tb_ppu_fix_responder;

    localparam int DIV_ITER = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ppu_valid_in = 1'b0;
    logic [31:0] ppu_in1 = 32'd0;
    logic [31:0] ppu_in2 = 32'd0;
    logic [2:0]  ppu_op = 3'd0;
    logic [31:0] ppu_out;
    logic        ppu_valid_o;
    logic        ppu_busy_o;

    int total = 0;
    int bad   = 0;

    ppu_fix_responder #(.PPU_OP_WIDTH(3), .DIV_ITER(DIV_ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .ppu_valid_in (ppu_valid_in),
        .ppu_in1      (ppu_in1),
        .ppu_in2      (ppu_in2),
        .ppu_op       (ppu_op),
        .ppu_out      (ppu_out),
        .ppu_valid_o  (ppu_valid_o),
        .ppu_busy_o   (ppu_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Q16.16 arithmetic from the rules, using wide integers.
    function automatic logic [31:0] m_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] o);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = (sa * sb) >>> 16;
            3'd3: begin
                if (sb == 0) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                r = (sa * 65536) / sb;
            end
            default: return 32'd0;
        endcase
        if (r > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (r < -64'sh8000_0000) return 32'h8000_0000;
        return 32'(r);
    endfunction

    function automatic int m_latency(input logic [31:0] b, input logic [2:0] o);
        return (o == 3'd3 && b != 32'd0) ? DIV_ITER + 2 : 2;
    endfunction

    // Model: cycles left until completion (0 = idle), pending and visible result.
    int          m_left = 0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_out  = 32'd0;
    bit          chk_en = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_left = 0;
            m_out  = 32'd0;
        end else if (m_left == 0) begin
            if (ppu_valid_in) begin
                m_left = m_latency(ppu_in2, ppu_op);
                m_pend = m_calc(ppu_in1, ppu_in2, ppu_op);
            end
        end else begin
            m_left--;
            if (m_left == 1) m_out = m_pend;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            check("cyc_valid", {31'd0, ppu_valid_o}, {31'd0, m_left == 1});
            check("cyc_busy",  {31'd0, ppu_busy_o},  {31'd0, m_left != 0});
            check("cyc_out",   ppu_out, m_out);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        ppu_in1      = a;
        ppu_in2      = b;
        ppu_op       = o;
        ppu_valid_in = 1'b1;
    endtask

    // Waits for the completion pulse; lat counts negedges from issue.
    task automatic await_done(input string name, input logic [31:0] exp, input int lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            #1;
            n++;
            if (ppu_valid_o) got = 1'b1;
        end
        check({name, "_pulse"}, {31'd0, got}, 32'd1);
        check({name, "_cycle"}, 32'(n), 32'(lat));
        check({name, "_out"}, ppu_out, exp);
        $display("txn %-10s out=0x%08h exp=0x%08h cycle=%0d", name, ppu_out, exp, n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15] = '{
        '{"add",       3'd0, 32'h0001_8000, 32'h0001_0000, 32'h0002_8000, 2},
        '{"sub_sat",   3'd1, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 2},
        '{"add_sat",   3'd0, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 2},
        '{"mul_neg",   3'd2, 32'hFFFE_0000, 32'h0001_8000, 32'hFFFD_0000, 2},
        '{"mul_sat",   3'd2, 32'h0100_0000, 32'h0100_0000, 32'h7FFF_FFFF, 2},
        '{"mul_floor", 3'd2, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 2},
        '{"div",       3'd3, 32'h0007_0000, 32'h0002_0000, 32'h0003_8000, 50},
        '{"div_neg",   3'd3, 32'hFFF9_0000, 32'h0002_0000, 32'hFFFC_8000, 50},
        '{"div_third", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 50},
        '{"div_nthrd", 3'd3, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 50},
        '{"div_psat",  3'd3, 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 50},
        '{"div_nmin",  3'd3, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 50},
        '{"div0_pos",  3'd3, 32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 2},
        '{"div0_neg",  3'd3, 32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 2},
        '{"reserved",  3'd5, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2}
    };

    initial begin
        rst = 1'b1;
        idle_cycles(3);
        check("rst_out",   ppu_out, 32'd0);
        check("rst_valid", {31'd0, ppu_valid_o}, 32'd0);
        check("rst_busy",  {31'd0, ppu_busy_o}, 32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;
        idle_cycles(2);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op);
            await_done(vecs[i].name, vecs[i].exp, vecs[i].lat);
            ppu_valid_in = 1'b0;
            idle_cycles(1);
        end

        // Back-to-back: valid stays high; second capture waits for IDLE.
        issue(32'h0001_8000, 32'h0001_0000, 3'd0);
        await_done("b2b_first", 32'h0002_8000, 2);
        issue(32'h0003_0000, 32'h0001_0000, 3'd1);
        await_done("b2b_second", 32'h0002_0000, 3);
        ppu_valid_in = 1'b0;
        idle_cycles(3);

        // Abort a divide at cycle 20 with reset.
        issue(32'h0007_0000, 32'h0002_0000, 3'd3);
        idle_cycles(20);
        rst          = 1'b1;
        ppu_valid_in = 1'b0;
        idle_cycles(1);
        check("abort_out",   ppu_out, 32'd0);
        check("abort_valid", {31'd0, ppu_valid_o}, 32'd0);
        check("abort_busy",  {31'd0, ppu_busy_o}, 32'd0);
        $display("txn abort      out=0x%08h busy=%0b valid=%0b", ppu_out, ppu_busy_o, ppu_valid_o);
        rst = 1'b0;
        idle_cycles(55);
        check("abort_quiet_out", ppu_out, 32'd0);
        issue(32'h0001_0000, 32'h0001_0000, 3'd0);
        await_done("post_abort", 32'h0002_0000, 2);
        ppu_valid_in = 1'b0;
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
